// File: rtl/eff_xfade_bypass.sv
// eff_xfade_bypass: click-free wet/dry bypass around an effect with
// sample-aligned latency. A dry-alignment FIFO re-pairs each dry sample with
// its wet counterpart, and enable changes ramp a linear crossfade gain g over
// R = 2^RAMP_LOG2 output samples.
// Build option: define EFF_XFADE_ROUND_EN to round the mix half up.
// Without it, the mix truncates toward negative infinity.
// Handshake: dry_vld_i and wet_vld_i are single-cycle strobes with no
// backpressure. Each wet_vld_i pops one dry word and produces exactly one
// vld_o strobe two cycles later. data_o holds its value between strobes.
module eff_xfade_bypass #(
  parameter int DATA_WIDTH = 24,
  parameter int NUM_CH     = 2,
  parameter int RAMP_LOG2  = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [NUM_CH*DATA_WIDTH-1:0] dry_i,
  input  logic                         dry_vld_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] wet_i,
  input  logic                         wet_vld_i,
  output logic [NUM_CH*DATA_WIDTH-1:0] data_o,
  output logic                         vld_o,
  output logic [1:0]                   state_o,
  output logic [1:0]                   err_o
);

  localparam int W  = NUM_CH * DATA_WIDTH;
  localparam int GW = RAMP_LOG2 + 1;
  localparam int PW = DATA_WIDTH + RAMP_LOG2 + 1;
  localparam int SW = PW + 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [GW-1:0] R_G    = {1'b1, {RAMP_LOG2{1'b0}}};
  localparam logic [GW-1:0] G_ZERO = '0;
  localparam logic [GW-1:0] G_ONE  = {{RAMP_LOG2{1'b0}}, 1'b1};
  localparam logic [AW:0]   P_ONE  = {{AW{1'b0}}, 1'b1};
`ifdef EFF_XFADE_ROUND_EN
  localparam logic signed [SW-1:0] RND = SW'(2 ** (RAMP_LOG2 - 1));
`else
  localparam logic signed [SW-1:0] RND = '0;
`endif

  typedef enum logic [1:0] {
    ST_BYPASS   = 2'd0,
    ST_FADE_IN  = 2'd1,
    ST_ON       = 2'd2,
    ST_FADE_OUT = 2'd3
  } state_t;

  // ---------------- dry-alignment FIFO ----------------
  logic [W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic         empty, full;
  logic         push_ok, pop_ok, fall_thru, ovf, unf;
  logic [W-1:0] dry_sel;
  logic [1:0]   err_q;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Pick the dry word paired with this wet strobe and classify push/pop.
  always_comb begin
    push_ok   = 1'b0;
    pop_ok    = 1'b0;
    fall_thru = 1'b0;
    ovf       = 1'b0;
    unf       = 1'b0;
    dry_sel   = '0;
    if (wet_vld_i) begin
      if (!empty) begin
        dry_sel = mem_q[rd_ptr_q[AW-1:0]];
        pop_ok  = 1'b1;
      end else if (dry_vld_i) begin
        dry_sel   = dry_i;
        fall_thru = 1'b1;
      end else begin
        unf = 1'b1;
      end
    end
    if (dry_vld_i && !fall_thru) begin
      // A simultaneous pop frees a slot, so a full FIFO still accepts the push.
      if (!full || wet_vld_i) push_ok = 1'b1;
      else                    ovf     = 1'b1;
    end
  end

  // FIFO storage; contents need no reset because the pointers gate every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= dry_i;
  end

  // FIFO pointers and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + P_ONE;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + P_ONE;
      err_q <= err_q | {unf, ovf};
    end
  end

  // ---------------- gain state machine ----------------
  state_t         state_q, state_d;
  logic [GW-1:0]  g_q, g_d;

  // State register: g and the fade state advance once per wet strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BYPASS;
      g_q     <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
    end
  end

  // Next-state logic. g saturates at 0 and R, so a reversal that reaches an
  // endpoint mid-fade can never wrap the gain.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    if (wet_vld_i) begin
      unique case (state_q)
        ST_BYPASS: begin
          if (en) begin
            state_d = ST_FADE_IN;
            g_d     = G_ONE;
          end else begin
            g_d = G_ZERO;
          end
        end
        ST_FADE_IN: begin
          if (!en) begin
            state_d = ST_FADE_OUT;
            g_d     = (g_q == G_ZERO) ? G_ZERO : g_q - G_ONE;
          end else begin
            g_d = (g_q == R_G) ? R_G : g_q + G_ONE;
            if (g_d == R_G) state_d = ST_ON;
          end
        end
        ST_ON: begin
          if (!en) begin
            state_d = ST_FADE_OUT;
            g_d     = R_G - G_ONE;
          end
        end
        ST_FADE_OUT: begin
          if (en) begin
            state_d = ST_FADE_IN;
            g_d     = (g_q == R_G) ? R_G : g_q + G_ONE;
          end else begin
            g_d = (g_q == G_ZERO) ? G_ZERO : g_q - G_ONE;
            if (g_d == G_ZERO) state_d = ST_BYPASS;
          end
        end
        default: begin
          state_d = ST_BYPASS;
          g_d     = G_ZERO;
        end
      endcase
    end
  end

  // Output logic: expose the fade state for monitoring.
  always_comb begin
    state_o = state_q;
  end

  // ---------------- mix pipeline ----------------
  logic [GW-1:0]        coef_dry;
  logic signed [PW-1:0] pd_d [NUM_CH];
  logic signed [PW-1:0] pw_d [NUM_CH];
  logic signed [PW-1:0] pd_q [NUM_CH];
  logic signed [PW-1:0] pw_q [NUM_CH];
  logic signed [SW-1:0] sum  [NUM_CH];
  logic [W-1:0]         mix_d;
  logic                 s1_vld_q;
  logic [W-1:0]         data_q;
  logic                 vld_q;

  assign coef_dry = R_G - g_q;

  // Stage 1 products: dry*(R-g) and wet*g using the gain before this sample's update.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      pd_d[c] = PW'($signed(dry_sel[c*DATA_WIDTH +: DATA_WIDTH])) * $signed(PW'(coef_dry));
      pw_d[c] = PW'($signed(wet_i[c*DATA_WIDTH +: DATA_WIDTH])) * $signed(PW'(g_q));
    end
  end

  // Stage 2 sum; taking bits above RAMP_LOG2 is the arithmetic shift.
  always_comb begin
    mix_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sum[c] = SW'(pd_q[c]) + SW'(pw_q[c]) + RND;
      mix_d[c*DATA_WIDTH +: DATA_WIDTH] = sum[c][RAMP_LOG2 +: DATA_WIDTH];
    end
  end

  // Pipeline registers; reset drops any in-flight sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      vld_q    <= 1'b0;
      data_q   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        pd_q[c] <= '0;
        pw_q[c] <= '0;
      end
    end else begin
      s1_vld_q <= wet_vld_i;
      vld_q    <= s1_vld_q;
      if (wet_vld_i) begin
        for (int c = 0; c < NUM_CH; c++) begin
          pd_q[c] <= pd_d[c];
          pw_q[c] <= pw_d[c];
        end
      end
      if (s1_vld_q) data_q <= mix_d;
    end
  end

  assign data_o = data_q;
  assign vld_o  = vld_q;
  assign err_o  = err_q;

endmodule
